// File: rtl/dot_result_collector.sv
// dot_result_collector
//   Collects a vector of NOE single-precision dot-product results arriving as
//   strobes, packs them NI lanes per word (first element in the most
//   significant lane), and streams the packed words to a vector memory through
//   a 2-deep registered FIFO with valid/ready handshaking. The source has no
//   backpressure: a word completed while the FIFO is full and not draining is
//   dropped and flagged through the sticky overflow output.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     pulse that begins collection of one result vector (IDLE only)
//   in_valid  one finished dot product on in_data (COLLECT only)
//   in_data   32-bit IEEE-754 result, passed through unmodified
//   wr_valid  head packed word is available
//   wr_ready  vector memory accepts the head word this cycle
//   wr_addr   word address of the head word
//   wr_data   packed head word, 32*NI bits
//   busy      high while collecting or flushing
//   done      one-cycle pulse once the final word has been written
//   overflow  sticky: a packed word was dropped

module dot_result_collector #(
    parameter int unsigned NOE    = 10,
    parameter int unsigned NI     = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic [31:0]         in_data,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [32*NI-1:0]    wr_data,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned CW = $clog2(NOE + 1);
    localparam int unsigned LW = $clog2(NI);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [LW-1:0]       lane;
    logic [32*NI-1:0]    pack;

    logic [32*NI-1:0]    mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          fifo_cnt;
    logic [1:0]          fifo_cnt_next;

    logic                capture;
    logic                last_elem;
    logic                last_lane;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                drop;
    logic [32*NI-1:0]    merged;

    assign capture   = (state == COLLECT) && in_valid;
    assign last_elem = (count == CW'(NOE - 1));
    assign last_lane = (lane == LW'(NI - 1));
    assign push      = capture && (last_lane || last_elem);
    assign pop       = (fifo_cnt != 2'd0) && wr_ready;
    assign full      = (fifo_cnt == 2'd2);
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    assign wr_data   = mem[rd_ptr];

    // Pack register with the incoming element merged into its lane; this is
    // both the next pack value and the word pushed when the word completes.
    always_comb begin
        merged = pack;
        for (int unsigned i = 0; i < NI; i++) begin
            if (lane == LW'(i)) begin
                merged[32*(NI-i)-1 -: 32] = in_data;
            end
        end
    end

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        case ({push_ok, pop})
            2'b10:   fifo_cnt_next = fifo_cnt + 2'd1;
            2'b01:   fifo_cnt_next = fifo_cnt - 2'd1;
            default: fifo_cnt_next = fifo_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            lane     <= '0;
            pack     <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Output FIFO runs in every state; it only holds words between a
            // push in COLLECT and the drain that ends FLUSH.
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (push_ok) begin
                mem[wr_ptr] <= merged;
                wr_ptr      <= ~wr_ptr;
            end
            fifo_cnt <= fifo_cnt_next;
            wr_valid <= (fifo_cnt_next != 2'd0);
            if (drop) begin
                overflow <= 1'b1;
            end

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        lane     <= '0;
                        pack     <= '0;
                        wr_addr  <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        count <= count + CW'(1);
                        lane  <= lane + LW'(1);
                        pack  <= push ? '0 : merged;
                        if (last_elem) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_cnt_next == 2'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dot_result_collector.md
DOT_RESULT_COLLECTOR -- requirements
Module: dot_result_collector

Interface
REQ-001 Parameter NOE, default 10: number of dot-product results (matrix rows) per vector; NOE >= 1.
REQ-002 Parameter NI, default 8: lanes per packed output word; power of two, >= 2.
REQ-003 Parameter ADDR_W, default 8: write-address width; ceil(NOE/NI) <= 2^ADDR_W.
REQ-004 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins collection of one result vector.
REQ-007 in_valid  input  1  single-cycle strobe marking one finished dot product; no backpressure exists toward the source.
REQ-008 in_data  input  32  IEEE-754 single-precision dot-product result, valid with in_valid.
REQ-009 wr_valid  output  1  head packed word available to the vector memory.
REQ-010 wr_ready  input  1  vector memory accepts the word this cycle.
REQ-011 wr_addr  output  ADDR_W  word address of the head word.
REQ-012 wr_data  output  32*NI  packed head word.
REQ-013 busy  output  1  high in COLLECT and FLUSH.
REQ-014 done  output  1  one-cycle pulse after the final word is written.
REQ-015 overflow  output  1  sticky error: a packed word was dropped.

Function
REQ-016 The block SHALL implement states IDLE, COLLECT, FLUSH and DONE.
REQ-017 IDLE: start SHALL clear the element count, pack register, and write address, then enter COLLECT; start SHALL be ignored in every other state.
REQ-018 COLLECT: on in_valid, element k = count mod NI SHALL be written to pack bits [32*(NI-k)-1 -: 32], so the first element occupies the most significant lane; count increments.
REQ-019 Data SHALL pass unmodified; the block performs no arithmetic on in_data.
REQ-020 A word SHALL be pushed into the output FIFO on the same edge that captures lane NI-1 or element NOE-1; lanes not yet written SHALL be zero; the pack register clears on that edge.
REQ-021 Total words per vector SHALL be ceil(NOE/NI); when NOE is a multiple of NI, no padded word is produced.
REQ-022 The output FIFO SHALL be 2 words deep and registered; wr_valid SHALL be high whenever it is non-empty, and wr_data is its head.
REQ-023 A word transfers on a cycle with wr_valid && wr_ready; wr_addr SHALL then increment by 1 (wrap modulo 2^ADDR_W).
REQ-024 A push into a full FIFO SHALL succeed when a pop occurs on the same cycle.
REQ-025 A push into a full FIFO without a same-cycle pop SHALL drop the word, set overflow, and still advance count and state.
REQ-026 wr_valid SHALL assert on the cycle after the pushing edge (1-cycle latency from the last element of a word).
REQ-027 After element NOE-1 is captured, the state SHALL become FLUSH; FLUSH SHALL go to DONE on the edge at which the FIFO becomes empty.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 in_valid outside COLLECT SHALL be ignored, with no state change.
REQ-030 overflow SHALL clear only on reset or on an accepted start.

Reset
REQ-031 While reset is high, the block SHALL enter IDLE and drive busy=0, done=0, wr_valid=0, overflow=0, wr_addr=0, and wr_data=0; FIFO, pack register, and count SHALL clear.
REQ-032 Reset during COLLECT or FLUSH SHALL discard all partial and buffered words; no write SHALL follow.

Verification
REQ-033 NOE=10, NI=8, wr_ready=1, start, then 10 strobes with data 1..10 -> word 0 at addr 0 = lanes 1..8 (MSB lane first); word 1 at addr 1 = 9,10 followed by six zero lanes; done pulses once; overflow=0.
REQ-034 NOE=24, wr_ready=0 throughout the 24 strobes -> words 0 and 1 held; word 2 is dropped and overflow=1; raising wr_ready then writes addr 0 and 1 followed by done.
REQ-035 FIFO full, with the final push and wr_ready=1 on the same cycle -> no overflow; all words are written in order.
REQ-036 NOE=16 -> exactly 2 writes with no zero-padded word.
REQ-037 Reset asserted after 5 strobes -> wr_valid=0 and busy=0 on the next cycle; a fresh start with 10 strobes gives the same result as REQ-033.
REQ-038 start pulsed during COLLECT, and in_valid strobed during IDLE -> both ignored; counts and data are unchanged.
